// File: rtl/ifq_pkg.sv
// Shared types and sizing for the instruction fetch queue.
//
// Contents:
//   IFQ_DEPTH, IFQ_INSTR_W, IFQ_ADDR_W  default geometry of the queue
//   IFQ_PTR_W                           pointer width (index bits + one wrap bit)
//   ifq_entry_t                         one queued {pc, instr} pair
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH   = 8;
    localparam int unsigned IFQ_INSTR_W = 32;
    localparam int unsigned IFQ_ADDR_W  = 64;
    localparam int unsigned IFQ_PTR_W   = $clog2(IFQ_DEPTH) + 1;

    typedef struct packed {
        logic [IFQ_ADDR_W-1:0]  pc;
        logic [IFQ_INSTR_W-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ptr.sv
// Wrap-bit pointer register for the instruction fetch queue.
//
// The low PTR_W-1 bits index storage; the MSB toggles on every wrap so that
// equal pointers mean empty and equal-low/different-MSB pointers mean full.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   clear  synchronous return to zero (wins over inc)
//   inc    advance by one on the next edge
//   ptr    current pointer value
module ifq_ptr
    import ifq_pkg::*;
#(
    parameter int unsigned PTR_W = IFQ_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            // Natural overflow of the full width gives the seamless wrap.
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: in-order FIFO of {instr, pc} pairs between fetch
// and decode, with a flush for branch redirects.
//
// Optional feature (macro IFQ_BYPASS_EN): when the queue is empty, an
// incoming entry is presented to decode in the same cycle; if decode takes it
// the entry is never written.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   flush      discard every queued entry on the next edge (highest priority)
//   enq_valid  fetch presents an entry
//   enq_ready  queue can accept an entry (depends only on registered state)
//   enq_instr  fetched instruction
//   enq_pc     PC of enq_instr
//   deq_valid  head entry available
//   deq_ready  decode consumes the head entry
//   deq_instr  head instruction (0 when deq_valid = 0)
//   deq_pc     head PC (0 when deq_valid = 0)
//   count      occupancy
//
// INSTR_W/ADDR_W must match the widths of ifq_entry_t in ifq_pkg.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH   = IFQ_DEPTH,
    parameter int unsigned INSTR_W = IFQ_INSTR_W,
    parameter int unsigned ADDR_W  = IFQ_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [INSTR_W-1:0]       enq_instr,
    input  logic [ADDR_W-1:0]        enq_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [INSTR_W-1:0]       deq_instr,
    output logic [ADDR_W-1:0]        deq_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             bypass_active;
    logic             rd_inc;
    logic             wr_inc;
    ifq_entry_t       head;
    ifq_entry_t       mem [DEPTH];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                   (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]);

`ifdef IFQ_BYPASS_EN
    assign bypass_active = empty && enq_valid && !flush;
`else
    assign bypass_active = 1'b0;
`endif

    assign enq_ready = !full;
    assign deq_valid = !empty || bypass_active;

    // A bypassed entry consumed by decode never touches storage or pointers.
    assign rd_inc = !empty && deq_ready;
    assign wr_inc = enq_valid && !full && !(bypass_active && deq_ready);

    // Modulo-2*DEPTH difference of the wrap-bit pointers is the occupancy.
    assign count = wr_ptr - rd_ptr;

    ifq_ptr #(
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (rd_inc),
        .ptr   (rd_ptr)
    );

    ifq_ptr #(
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (wr_inc),
        .ptr   (wr_ptr)
    );

    // Storage is intentionally not reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (wr_inc && !flush) begin
            mem[wr_ptr[IDX_W-1:0]] <= '{pc: enq_pc, instr: enq_instr};
        end
    end

    assign head = mem[rd_ptr[IDX_W-1:0]];

    always_comb begin
        deq_instr = '0;
        deq_pc    = '0;
        if (!empty) begin
            deq_instr = head.instr;
            deq_pc    = head.pc;
        end else if (bypass_active) begin
            deq_instr = enq_instr;
            deq_pc    = enq_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               enq_valid;
    logic               enq_ready;
    logic [INSTR_W-1:0] enq_instr;
    logic [ADDR_W-1:0]  enq_pc;
    logic               deq_valid;
    logic               deq_ready;
    logic [INSTR_W-1:0] deq_instr;
    logic [ADDR_W-1:0]  deq_pc;
    logic [3:0]         count;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_queue #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_instr (enq_instr),
        .enq_pc    (enq_pc),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_instr (deq_instr),
        .deq_pc    (deq_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] instr, input logic [63:0] pc);
        enq_valid = 1'b1;
        enq_instr = instr;
        enq_pc    = pc;
        step();
        enq_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_instr = '0;
        enq_pc    = '0;
        deq_ready = 1'b0;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_deq_instr", 64'(deq_instr), 64'd0);
        reset = 1'b1;
        step();

        // 1: three enqueues, decode stalled
        for (int i = 0; i < 3; i++) enq(32'h8B02_0020 + 32'(i), 64'(4 * i));
        check("t1_count", 64'(count), 64'd3);
        check("t1_deq_valid", 64'(deq_valid), 64'd1);
        check("t1_deq_instr", 64'(deq_instr), 64'h8B02_0020);
        check("t1_deq_pc", deq_pc, 64'h0);

        // 2: fill, refuse extra, drain in order
        for (int i = 3; i < 8; i++) enq(32'h8B02_0020 + 32'(i), 64'(4 * i));
        check("t2_full_count", 64'(count), 64'd8);
        check("t2_enq_ready", 64'(enq_ready), 64'd0);
        enq(32'hDEAD_BEEF, 64'hFFFF);
        check("t2_extra_count", 64'(count), 64'd8);
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_instr%0d", i), 64'(deq_instr), 64'(32'h8B02_0020 + 32'(i)));
            check($sformatf("t2_pc%0d", i), deq_pc, 64'(4 * i));
            step();
        end
        deq_ready = 1'b0;
        check("t2_deq_valid", 64'(deq_valid), 64'd0);
        check("t2_count", 64'(count), 64'd0);

        // 3: full with simultaneous enq and deq
        for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(i), 64'h100 + 64'(i));
        enq_valid = 1'b1;
        enq_instr = 32'h2000;
        enq_pc    = 64'h200;
        deq_ready = 1'b1;
        #1;
        check("t3_enq_ready_full", 64'(enq_ready), 64'd0);
        step();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("t3_count", 64'(count), 64'd7);
        check("t3_enq_ready", 64'(enq_ready), 64'd1);
        check("t3_head", 64'(deq_instr), 64'h1001);
        deq_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t3_drain%0d", i), 64'(deq_instr), 64'(32'h1000 + 32'(i)));
            step();
        end
        deq_ready = 1'b0;
        check("t3_empty", 64'(deq_valid), 64'd0);

        // 4: steady streaming through 20 entries
        enq(32'h3000, 64'h3000);
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_valid = 1'b1;
            enq_instr = 32'h3001 + 32'(i);
            enq_pc    = 64'h3001 + 64'(i);
            #1;
            check($sformatf("t4_out%0d", i), 64'(deq_instr), 64'(32'h3000 + 32'(i)));
            step();
            check($sformatf("t4_count%0d", i), 64'(count), 64'd1);
        end
        enq_valid = 1'b0;
        check("t4_last", 64'(deq_instr), 64'h3014);
        step();
        deq_ready = 1'b0;
        check("t4_count_end", 64'(count), 64'd0);

        // 5: flush with an enqueue in the same cycle
        for (int i = 0; i < 5; i++) enq(32'h4000 + 32'(i), 64'h40 + 64'(i));
        check("t5_count5", 64'(count), 64'd5);
        flush = 1'b1;
        enq(32'h4FFF, 64'h4FFF);
        flush = 1'b0;
        check("t5_count", 64'(count), 64'd0);
        check("t5_deq_valid", 64'(deq_valid), 64'd0);
        enq(32'h5000, 64'h50);
        check("t5_after_count", 64'(count), 64'd1);
        check("t5_after_head", 64'(deq_instr), 64'h5000);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // 6: asynchronous reset between edges
        for (int i = 0; i < 4; i++) enq(32'h6000 + 32'(i), 64'h60 + 64'(i));
        check("t6_count4", 64'(count), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        check("t6_deq_valid", 64'(deq_valid), 64'd0);
        check("t6_enq_ready", 64'(enq_ready), 64'd1);
        check("t6_count", 64'(count), 64'd0);
        #1;
        reset = 1'b1;
        step();

`ifdef IFQ_BYPASS_EN
        enq_valid = 1'b1;
        enq_instr = 32'hD65F_03C0;
        enq_pc    = 64'h70;
        deq_ready = 1'b1;
        #1;
        check("byp_valid", 64'(deq_valid), 64'd1);
        check("byp_instr", 64'(deq_instr), 64'hD65F_03C0);
        check("byp_pc", deq_pc, 64'h70);
        step();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("byp_count", 64'(count), 64'd0);
        check("byp_empty", 64'(deq_valid), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
